// File: rtl/cp0_regfile_pkg.sv
// CP0 register indices, exception codes and Status/Cause layouts shared by the CP0 files.
// Layout-only package; no logic.
package cp0_regfile_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0A,
    EXC_OV   = 5'h0C
  } exccode_t;

  typedef struct packed {
    logic [8:0] rsvd_31_23;
    logic       bev;
    logic [5:0] rsvd_21_16;
    logic [7:0] im;
    logic [5:0] rsvd_7_2;
    logic       exl;
    logic       ie;
  } cp0_status_t;

  typedef struct packed {
    logic        bd;
    logic        ti;
    logic [13:0] rsvd_29_16;
    logic [7:0]  ip;
    logic        rsvd_7;
    logic [4:0]  exccode;
    logic [1:0]  rsvd_1_0;
  } cp0_cause_t;

endpackage

// File: rtl/cp0_regfile_if.sv
// Pipeline <-> CP0 signal bundle: mfc0/mtc0 port, exception/ERET commit and redirect.
// master = pipeline side, slave = CP0 side.
interface cp0_regfile_if;
  logic [4:0]  ra;
  logic [31:0] rd;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_in_ds;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [5:0]  ext_int;
  logic        int_pending;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] epc;

  modport master (
    output ra, we, wa, wd, exc_valid, exc_code, exc_pc, exc_in_ds, exc_badvaddr, eret, ext_int,
    input  rd, int_pending, redirect_valid, redirect_pc, epc
  );

  modport slave (
    input  ra, we, wa, wd, exc_valid, exc_code, exc_pc, exc_in_ds, exc_badvaddr, eret, ext_int,
    output rd, int_pending, redirect_valid, redirect_pc, epc
  );
endinterface

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer with half-rate tick and sticky TI; only built when CP0_TIMER_EN is defined.
// Count write beats the increment; Compare write clears TI and beats a same-cycle set.
`ifdef CP0_TIMER_EN
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wd_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic        tick_q, tick_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  always_comb begin
    tick_d    = ~tick_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we_i) begin
      count_d = wd_i;
    end else if (!tick_q) begin
      count_d = count_q + 32'd1;
      if (count_d == compare_q) ti_d = 1'b1;
    end
    if (compare_we_i) begin
      compare_d = wd_i;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q    <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule
`endif

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file and exception commit: records exceptions, serves mfc0/mtc0/ERET, raises int_pending.
// Timer (Count/Compare/TI) is present only when CP0_TIMER_EN is defined.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] VEC_BEV    = 32'hBFC0_0380,
  parameter logic [31:0] VEC_NORMAL = 32'h8000_0180
) (
  input  logic          clk,
  input  logic          reset,
  cp0_regfile_if.slave  bus
);

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ext_q;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic        do_exc, do_eret, do_we;
  logic [31:0] count, compare;
  logic        ti;
  cp0_status_t status;
  cp0_cause_t  cause;

  // Commit priority: exception beats ERET beats mtc0.
  assign do_exc  = bus.exc_valid;
  assign do_eret = bus.eret & ~bus.exc_valid;
  assign do_we   = bus.we & ~bus.exc_valid & ~bus.eret;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk          (clk),
    .reset        (reset),
    .count_we_i   (do_we && bus.wa == CP0_COUNT),
    .compare_we_i (do_we && bus.wa == CP0_COMPARE),
    .wd_i         (bus.wd),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif

  always_comb begin
    status     = '0;
    status.bev = 1'b1;
    status.im  = im_q;
    status.exl = exl_q;
    status.ie  = ie_q;
    cause         = '0;
    cause.bd      = bd_q;
    cause.ti      = ti;
    cause.ip      = {ext_q[5] | ti, ext_q[4:0], ip_sw_q};
    cause.exccode = exccode_q;
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    if (do_exc) begin
      exl_d     = 1'b1;
      exccode_d = bus.exc_code;
      if (!exl_q) begin
        epc_d = bus.exc_in_ds ? bus.exc_pc - 32'd4 : bus.exc_pc;
        bd_d  = bus.exc_in_ds;
      end
      if (exccode_t'(bus.exc_code) == EXC_ADEL || exccode_t'(bus.exc_code) == EXC_ADES)
        badvaddr_d = bus.exc_badvaddr;
    end else if (do_eret) begin
      exl_d = 1'b0;
    end else if (do_we) begin
      case (bus.wa)
        CP0_STATUS: begin
          im_d  = bus.wd[15:8];
          exl_d = bus.wd[1];
          ie_d  = bus.wd[0];
        end
        CP0_CAUSE: ip_sw_d = bus.wd[9:8];
        CP0_EPC:   epc_d   = bus.wd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_sw_q    <= '0;
      ext_q      <= '0;
      exccode_q  <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
      ext_q      <= bus.ext_int;
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  always_comb begin
    case (bus.ra)
      CP0_BADVADDR: bus.rd = badvaddr_q;
      CP0_COUNT:    bus.rd = count;
      CP0_COMPARE:  bus.rd = compare;
      CP0_STATUS:   bus.rd = status;
      CP0_CAUSE:    bus.rd = cause;
      CP0_EPC:      bus.rd = epc_q;
      default:      bus.rd = '0;
    endcase
  end

  assign bus.int_pending    = status.ie & ~status.exl & |(cause.ip & status.im);
  // Redirects are dropped while reset is held.
  assign bus.redirect_valid = ~reset & (bus.exc_valid | bus.eret);
  assign bus.redirect_pc    = bus.exc_valid ? (status.bev ? VEC_BEV : VEC_NORMAL) : epc_q;
  assign bus.epc            = epc_q;

endmodule
